// File: rtl/i2s_clk_ws_gen.sv
// i2s_clk_ws_gen: I2S/TDM master SCK/WS generator with frame-aligned glitch-free stop.
// Optional I2S_CLKGEN_DFT_EN routes sck_o through pulp_clock_mux2 for clk_i bypass.
`default_nettype none

module i2s_clk_ws_gen #(
   parameter int unsigned DIV_W  = 16,
   parameter int unsigned SLOT_W = 3,
   parameter int unsigned BIT_W  = 5
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              test_mode_i,
   input  logic              cfg_clk_en_i,
   input  logic [DIV_W-1:0]  cfg_div_i,
   input  logic [BIT_W-1:0]  cfg_word_size_i,
   input  logic [SLOT_W-1:0] cfg_num_slots_i,
   input  logic              cfg_ws_mode_i,
   output logic              cfg_clk_en_o,
   output logic              sck_o,
   output logic              ws_o,
   output logic              sck_rise_o,
   output logic              sck_fall_o,
   output logic              frame_start_o,
   output logic [SLOT_W-1:0] slot_o,
   output logic [BIT_W-1:0]  bit_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              state;
   logic                en;
   logic                pend;
   logic                sck;
   logic                ws;
   logic                rise;
   logic                fall;
   logic                fstart;
   logic [DIV_W-1:0]    cnt;
   logic [DIV_W-1:0]    div_s;
   logic [BIT_W-1:0]    word_s;
   logic [SLOT_W-1:0]   slots_s;
   logic                mode_s;
   logic [BIT_W-1:0]    bit_idx;
   logic [SLOT_W-1:0]   slot_idx;

   logic                last_bit;
   logic                frame_end;
   logic [BIT_W-1:0]    nxt_bit;
   logic [SLOT_W-1:0]   nxt_slot;

   assign last_bit  = (bit_idx == word_s);
   assign frame_end = last_bit && (slot_idx == slots_s);
   assign nxt_bit   = last_bit ? '0 : bit_idx + 1'b1;
   assign nxt_slot  = !last_bit ? slot_idx : (frame_end ? '0 : slot_idx + 1'b1);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state    <= IDLE;
         en       <= 1'b0;
         pend     <= 1'b0;
         sck      <= 1'b0;
         ws       <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
         fstart   <= 1'b0;
         cnt      <= '0;
         div_s    <= '0;
         word_s   <= '0;
         slots_s  <= '0;
         mode_s   <= 1'b0;
         bit_idx  <= '0;
         slot_idx <= '0;
      end else begin
         rise   <= 1'b0;
         fall   <= 1'b0;
         fstart <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_clk_en_i) begin
                  state    <= RUN;
                  en       <= 1'b1;
                  pend     <= 1'b0;
                  div_s    <= cfg_div_i;
                  word_s   <= cfg_word_size_i;
                  slots_s  <= cfg_num_slots_i;
                  mode_s   <= cfg_ws_mode_i;
                  cnt      <= '0;
                  sck      <= 1'b0;
                  bit_idx  <= '0;
                  slot_idx <= '0;
                  ws       <= cfg_ws_mode_i;
                  fstart   <= 1'b1;
               end
            end
            // One dead cycle after a stop so a still-high request restarts cleanly.
            HOLD: state <= IDLE;
            RUN: begin
               pend <= !cfg_clk_en_i;
               if (cnt == div_s) begin
                  cnt <= '0;
                  if (!sck) begin
                     sck  <= 1'b1;
                     rise <= 1'b1;
                  end else begin
                     sck  <= 1'b0;
                     fall <= 1'b1;
                     if (frame_end && pend) begin
                        state    <= HOLD;
                        en       <= 1'b0;
                        pend     <= 1'b0;
                        bit_idx  <= '0;
                        slot_idx <= '0;
                        ws       <= 1'b0;
                     end else begin
                        bit_idx  <= nxt_bit;
                        slot_idx <= nxt_slot;
                        if (frame_end) begin
                           div_s   <= cfg_div_i;
                           word_s  <= cfg_word_size_i;
                           slots_s <= cfg_num_slots_i;
                           mode_s  <= cfg_ws_mode_i;
                           ws      <= cfg_ws_mode_i;
                           fstart  <= 1'b1;
                        end else if (mode_s) begin
                           ws <= (nxt_slot == '0) && (nxt_bit == '0);
                        end else begin
                           ws <= nxt_slot[0];
                        end
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign cfg_clk_en_o  = en;
   assign ws_o          = ws;
   assign sck_rise_o    = rise;
   assign sck_fall_o    = fall;
   assign frame_start_o = fstart;
   assign slot_o        = slot_idx;
   assign bit_o         = bit_idx;

`ifdef I2S_CLKGEN_DFT_EN
   pulp_clock_mux2 i_sck_mux (
      .clk0_i    (sck),
      .clk1_i    (clk_i),
      .clk_sel_i (test_mode_i),
      .clk_o     (sck_o)
   );
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode_i;
   assign sck_o            = sck;
`endif

endmodule

`default_nettype wire

// File: doc/i2s_clk_ws_gen.md
# i2s_clk_ws_gen

Parametrised I2S/TDM master clock generator for the uDMA I2S subsystem. It divides the system clock to produce the serial bit clock (SCK) and derives the word-select/frame-sync (WS), slot index and bit index from it. Enable and disable are glitch-free, and a disable request stops the clock only at a frame boundary. Serializer/deserializer logic in the I2S channel consumes its single-cycle edge strobes instead of sampling SCK as data.

## Interface

Parameters:
- DIV_W, 16, width of the half-period divider.
- SLOT_W, 3, width of the slot index; up to 2^SLOT_W slots per frame.
- BIT_W, 5, width of the bit index; up to 2^BIT_W bits per slot.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- test_mode_i  in  1  DFT clock bypass select; used only with I2S_CLKGEN_DFT_EN.
- cfg_clk_en_i  in  1  enable request.
- cfg_div_i  in  DIV_W  SCK half-period minus 1, in clk_i cycles.
- cfg_word_size_i  in  BIT_W  bits per slot minus 1.
- cfg_num_slots_i  in  SLOT_W  slots per frame minus 1.
- cfg_ws_mode_i  in  1  0 = LJ/I2S (WS = slot LSB), 1 = DSP (one-bit frame-sync pulse).
- cfg_clk_en_o  out  1  generator running.
- sck_o  out  1  bit clock.
- ws_o  out  1  word select / frame sync.
- sck_rise_o  out  1  one-cycle strobe in the first clk_i cycle with sck_o high.
- sck_fall_o  out  1  one-cycle strobe in the first clk_i cycle with sck_o low.
- frame_start_o  out  1  one-cycle strobe at the start of each frame.
- slot_o  out  SLOT_W  slot of the current bit.
- bit_o  out  BIT_W  bit within the slot.

## Operation

- Reset: all outputs are 0, and all counters and sampled configuration registers are 0.
- Idle (r_en=0) to run: on cfg_clk_en_i=1, in the same edge:
  - sample div, word_size, num_slots and ws_mode;
  - counter=0, sck=0, bit=0, slot=0;
  - ws = 1 if ws_mode=1, else 0;
  - cfg_clk_en_o=1 and frame_start_o pulses.
- Divider: while running, the counter increments each cycle. When it equals sampled div, the counter goes to 0 and sck toggles. Half-period is div+1 cycles; div=0 gives clk_i/2.
- Falling SCK edge (sck 1 to 0):
  - sck_fall_o pulses.
  - If bit==word_size: bit=0, and slot advances. Otherwise bit+1.
  - If slot was also num_slots (frame end): slot=0, frame_start_o pulses, and all four config fields are resampled. Config is never resampled mid-frame.
  - ws updates in the same edge:
    - mode 0: ws = new slot[0];
    - mode 1: ws = 1 only when the new (slot,bit) = (0,0).
- Rising SCK edge: sck_rise_o pulses. bit, slot and ws are stable across every rising edge.
- Disable request (cfg_clk_en_i=0 while running): latched as stop-pending. SCK continues until the frame-end falling edge.
  - At that edge: sck=0, counter=0, bit=0, slot=0, ws=0, cfg_clk_en_o=0.
  - frame_start_o does not pulse, and no config resample occurs.
- Re-enable while stop-pending: the pending request is cleared and the frame continues uninterrupted.
- Re-enable in the cycle cfg_clk_en_o falls: ignored in that cycle; the generator restarts on the next cycle if the request is still high.
- Degenerate configs:
  - word_size=0: 1-bit slots.
  - num_slots=0: single slot; mode 0 ws stays 0.
  - Both 0 in mode 1: ws stays 1.
- Reset mid-operation: immediate return to reset values. No completion of the frame.

## Timing

- Enable to first sck_o rise: div+1 cycles after the cycle cfg_clk_en_o goes high.
- SCK period: 2(div+1) cycles. Frame: (word_size+1)(num_slots+1) SCK periods.
- All outputs are registered. Strobes coincide with the new sck_o level, not the cycle before it.
- sck_o duty is exactly 50%. No runt pulses on enable, disable or config change.

## Configuration

- I2S_CLKGEN_DFT_EN defined: sck_o is driven through pulp_clock_mux2.
  - test_mode_i=1 gives sck_o = clk_i.
  - test_mode_i=0 gives the internal SCK.
  - Strobes and ws are unaffected.
- Undefined: sck_o = internal SCK and test_mode_i is ignored.

## Test plan

- div=1, word=15, slots=1, mode 0, enable: sck period 4 cycles; ws 0 for 16 SCK, then 1 for 16; frame_start_o every 128 cycles; first rise 2 cycles after cfg_clk_en_o.
- div=0, word=7, slots=3, mode 1: ws high for exactly one SCK period (2 cycles) every 64 cycles; slot_o walks 0 through 3.
- Disable at slot 0 bit 5 of a 16x2 frame: SCK runs to the end of slot 1 bit 15. cfg_clk_en_o falls with the final falling edge; afterwards sck_o=0 and no strobes.
- div changed 1 to 3 at slot 0 bit 3: period stays 4 until the frame boundary, then becomes 8. Re-enable while stop-pending: no gap in SCK.
- rstn_i low mid-frame while sck_o=1: all outputs 0 asynchronously; no strobes after release until re-enabled.
- With I2S_CLKGEN_DFT_EN and test_mode_i=1: sck_o toggles with clk_i.
